// File: rtl/tsn_pri_sched_sel.sv
// Strict-priority queue selector: grants the highest eligible queue, then tracks that queue's frame on the MAC TX stream.
// Latency: grant one cycle after i_queue_vld; requests arriving while busy are dropped, not queued.
module tsn_pri_sched_sel #(
    parameter int PORT_FIFO_PRI_NUM = 8,
    parameter int TIMEOUT_CYC       = 4096
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_sched_en,
    input  logic [PORT_FIFO_PRI_NUM-1:0] i_queue,
    input  logic                         i_queue_vld,
    input  logic                         i_mac_tx_axis_valid,
    input  logic                         i_mac_tx_axis_last,
    input  logic [15:0]                  i_mac_tx_axis_user,
    output logic [PORT_FIFO_PRI_NUM-1:0] o_scheduing_rst,
    output logic                         o_scheduing_rst_vld,
    output logic                         o_busy,
    output logic                         o_timeout_err
);

    localparam int          N       = PORT_FIFO_PRI_NUM;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        WAIT_TX = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_grant_nxt;
    logic [N-1:0]   w_onehot;
    logic [N-1:0]   w_user;
    logic           r_grant_vld;
    logic           w_grant_vld_nxt;
    logic           r_busy;
    logic           w_busy_nxt;
    logic           r_timeout;
    logic           w_timeout_nxt;
    logic [15:0]    r_cnt;
    logic [15:0]    w_cnt_nxt;
    logic [15:0]    w_cnt_inc;
    logic           w_match;
    logic           w_user_unused;

    assign w_user        = i_mac_tx_axis_user[N-1:0];
    assign w_user_unused = ^i_mac_tx_axis_user;
    assign w_match       = i_mac_tx_axis_valid && (|(w_user & r_grant));
    assign w_cnt_inc     = r_cnt + 16'd1;

    // Last set bit wins, so the result is the one-hot of the highest eligible queue.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (i_queue[i]) begin
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_grant_vld_nxt = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_cnt_nxt       = '0;
        case (r_state)
            IDLE: begin
                if (i_queue_vld && i_sched_en && (|i_queue)) begin
                    w_grant_nxt     = w_onehot;
                    w_grant_vld_nxt = 1'b1;
                    w_state_nxt     = GRANT;
                end
            end
            GRANT: begin
                w_state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                // A matching beat in the expiry cycle still wins over the timeout.
                if (w_match) begin
                    w_state_nxt = i_mac_tx_axis_last ? IDLE : SEND;
                end else if (w_cnt_inc == TO_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            SEND: begin
                if (i_mac_tx_axis_valid && i_mac_tx_axis_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_grant_vld <= w_grant_vld_nxt;
            r_busy      <= w_busy_nxt;
            r_timeout   <= w_timeout_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign o_scheduing_rst     = r_grant;
    assign o_scheduing_rst_vld = r_grant_vld;
    assign o_busy              = r_busy;
    assign o_timeout_err       = r_timeout;

endmodule

// File: tb/tb_tsn_pri_sched_sel.sv
// Directed bench for tsn_pri_sched_sel: expected grants/timeouts are queued with their cycle, a negedge monitor pops and compares.
module tb_tsn_pri_sched_sel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_en = 1'b1;
    logic [7:0]  i_queue = '0;
    logic        i_qvld = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_last = 1'b0;
    logic [15:0] i_user = '0;
    logic [7:0]  o_grant;
    logic        o_grant_vld;
    logic        o_busy;
    logic        o_to;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit         kind;  // 0 = grant, 1 = timeout
        logic [7:0] val;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    tsn_pri_sched_sel #(
        .PORT_FIFO_PRI_NUM(8),
        .TIMEOUT_CYC(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sched_en(i_en),
        .i_queue(i_queue),
        .i_queue_vld(i_qvld),
        .i_mac_tx_axis_valid(i_valid),
        .i_mac_tx_axis_last(i_last),
        .i_mac_tx_axis_user(i_user),
        .o_scheduing_rst(o_grant),
        .o_scheduing_rst_vld(o_grant_vld),
        .o_busy(o_busy),
        .o_timeout_err(o_to)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_grant_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected got=%h cyc=%0d", o_grant, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.kind != 1'b0 || e.val != o_grant || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL grant got=%h@%0d want kind=%0d val=%h@%0d",
                                 o_grant, cyc, e.kind, e.val, e.cyc);
                    end
                end
            end
            if (o_to) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL timeout_unexpected cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.kind != 1'b1 || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL timeout got@%0d want kind=%0d @%0d", cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic push(input bit kind, input logic [7:0] val, input int c);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic req(input logic [7:0] q, input logic en);
        i_queue = q;
        i_en    = en;
        i_qvld  = 1'b1;
        step();
        i_qvld  = 1'b0;
        i_queue = '0;
        i_en    = 1'b1;
    endtask

    task automatic beat(input logic [15:0] u, input logic l);
        i_valid = 1'b1;
        i_user  = u;
        i_last  = l;
        step();
        i_valid = 1'b0;
        i_user  = '0;
        i_last  = 1'b0;
    endtask

    initial begin
        steps(2);
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_vld", 32'(o_grant_vld), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_to", 32'(o_to), 32'h0);
        rst = 1'b0;
        step();

        // Priority: 0010_0110 -> q5
        push(1'b0, 8'h20, cyc + 1);
        req(8'h26, 1'b1);
        check("pri_busy", 32'(o_busy), 32'h1);
        check("pri_grant", 32'(o_grant), 32'h20);
        step();
        beat(16'h0020, 1'b1);
        check("single_beat_idle", 32'(o_busy), 32'h0);
        check("grant_hold", 32'(o_grant), 32'h20);

        // Four-beat frame on q2 with a foreign beat, a gap, en low and an ignored request
        push(1'b0, 8'h04, cyc + 1);
        req(8'h04, 1'b1);
        step();
        beat(16'h0001, 1'b0);
        check("foreign_beat_busy", 32'(o_busy), 32'h1);
        beat(16'h0004, 1'b0);
        i_en = 1'b0;
        beat(16'h0004, 1'b0);
        step();
        req(8'hFF, 1'b1);
        check("send_busy", 32'(o_busy), 32'h1);
        beat(16'h0004, 1'b0);
        beat(16'h0004, 1'b1);
        check("frame_end_idle", 32'(o_busy), 32'h0);
        push(1'b0, 8'h01, cyc + 1);
        req(8'h01, 1'b1);
        step();
        beat(16'h0001, 1'b1);
        check("q0_done", 32'(o_busy), 32'h0);

        // Empty mask and disabled scheduler
        req(8'h00, 1'b1);
        check("empty_busy", 32'(o_busy), 32'h0);
        req(8'hFF, 1'b0);
        check("dis_busy", 32'(o_busy), 32'h0);
        step();
        check("dis_busy2", 32'(o_busy), 32'h0);

        // Timeout on q7: pulse 16 cycles after the grant cycle
        push(1'b0, 8'h80, cyc + 1);
        push(1'b1, 8'h00, cyc + 17);
        req(8'h80, 1'b1);
        step();
        beat(16'h0001, 1'b1);
        steps(15);
        check("to_idle", 32'(o_busy), 32'h0);

        // Matching beat in the expiry cycle beats the timeout
        push(1'b0, 8'h40, cyc + 1);
        req(8'h40, 1'b1);
        steps(15);
        beat(16'h0040, 1'b1);
        check("prec_idle", 32'(o_busy), 32'h0);
        steps(3);

        // Reset mid-frame
        push(1'b0, 8'h02, cyc + 1);
        req(8'h02, 1'b1);
        step();
        beat(16'h0002, 1'b0);
        beat(16'h0002, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_grant", 32'(o_grant), 32'h0);
        check("arst_vld", 32'(o_grant_vld), 32'h0);
        check("arst_busy", 32'(o_busy), 32'h0);
        check("arst_to", 32'(o_to), 32'h0);
        step();
        rst = 1'b0;
        step();
        push(1'b0, 8'h10, cyc + 1);
        req(8'h10, 1'b1);
        check("post_rst_grant", 32'(o_grant), 32'h10);
        step();
        beat(16'h0010, 1'b1);
        check("post_rst_idle", 32'(o_busy), 32'h0);
        steps(3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tsn_pri_sched_sel.md
TSN_PRI_SCHED_SEL -- requirements
Module: tsn_pri_sched_sel

Interface
REQ-001 SHALL have parameter PORT_FIFO_PRI_NUM, default 8: number of priority queues per port; queue index 7 is highest priority.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096: maximum cycles to wait for the first granted beat.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock, 250 MHz.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_sched_en, input, 1 bit: enables new selections.
REQ-006 SHALL have port i_queue, input, PORT_FIFO_PRI_NUM bits: eligible-queue mask from the shaper.
REQ-007 SHALL have port i_queue_vld, input, 1 bit: i_queue valid, single-cycle pulse.
REQ-008 SHALL have port i_mac_tx_axis_valid, input, 1 bit: MAC TX beat valid.
REQ-009 SHALL have port i_mac_tx_axis_last, input, 1 bit: MAC TX last beat.
REQ-010 SHALL have port i_mac_tx_axis_user, input, 16 bits: bit[q] set marks a beat from queue q.
REQ-011 SHALL have port o_scheduing_rst, output, PORT_FIFO_PRI_NUM bits: one-hot grant.
REQ-012 SHALL have port o_scheduing_rst_vld, output, 1 bit: grant valid, single-cycle pulse.
REQ-013 SHALL have port o_busy, output, 1 bit: high while a grant is outstanding.
REQ-014 SHALL have port o_timeout_err, output, 1 bit: single-cycle pulse when the wait for the granted frame times out.

Function
REQ-015 SHALL implement an FSM with states IDLE, GRANT, WAIT_TX and SEND; all outputs SHALL be registered.
REQ-016 In IDLE, a cycle with i_queue_vld=1, i_sched_en=1 and i_queue!=0 SHALL latch the one-hot of the highest set bit of i_queue and move to GRANT.
REQ-017 In IDLE, i_queue_vld=1 with i_queue=0 or i_sched_en=0 SHALL be dropped; the FSM stays in IDLE and no grant is issued.
REQ-018 In GRANT, o_scheduing_rst SHALL be driven with the latched one-hot and o_scheduing_rst_vld=1 for exactly one cycle.
- Latency: i_queue_vld sampled in cycle N, grant visible in cycle N+1.
- The next state is WAIT_TX.
REQ-019 o_scheduing_rst SHALL hold its value until the next grant; o_scheduing_rst_vld SHALL be 0 outside GRANT.
REQ-020 i_queue_vld SHALL be ignored in GRANT, WAIT_TX and SEND; no queuing of requests.
REQ-021 In WAIT_TX, a 16-bit wait counter SHALL increment every cycle from 0.
REQ-022 In WAIT_TX, a beat with valid=1 and user[granted]=1 SHALL clear the counter.
- With last=0 on that beat: next state SEND.
- With last=1 on that beat (single-beat frame): next state IDLE.
REQ-023 In WAIT_TX, beats whose user bit does not match the grant SHALL be ignored.
REQ-024 In WAIT_TX, when the counter reaches TIMEOUT_CYC-1 with no matching beat, the block SHALL pulse o_timeout_err for one cycle, clear the counter and return to IDLE.
- A matching beat in that same cycle SHALL take precedence over the timeout.
REQ-025 In SEND, a cycle with valid=1 and last=1 SHALL return the FSM to IDLE.
- The user field is not checked in SEND.
- Valid gaps are allowed, with no timeout.
REQ-026 Deasserting i_sched_en in GRANT, WAIT_TX or SEND SHALL NOT abort the operation; only the next selection is blocked.
REQ-027 o_busy SHALL be 1 in GRANT, WAIT_TX and SEND, and 0 in IDLE.
- IDLE is re-entered the cycle after last, so a new i_queue_vld is accepted from that cycle on.
REQ-028 Only bits [PORT_FIFO_PRI_NUM-1:0] of i_mac_tx_axis_user SHALL be used.

Reset
REQ-029 When i_rst=1, the block SHALL asynchronously reset to:
- FSM in IDLE and counter=0;
- o_scheduing_rst=0, o_scheduing_rst_vld=0, o_busy=0, o_timeout_err=0.
REQ-030 A reset asserted mid-frame SHALL abandon the outstanding grant; after release the first accepted i_queue_vld starts a fresh selection.

Verification
REQ-031 Priority test: i_queue=8'b0010_0110 with vld in cycle N -> o_scheduing_rst=8'h20 and vld=1 in cycle N+1; o_busy=1.
REQ-032 Full frame test: grant q2, then a 4-beat frame with user=16'h0004 and last on beat 4 -> o_busy falls the cycle after last; a new i_queue_vld=8'h01 is then granted as 8'h01.
REQ-033 Empty and disabled test: i_queue=0 with vld=1, then i_sched_en=0 with i_queue=8'hFF and vld=1 -> no grant and o_busy stays 0.
REQ-034 Timeout test: TIMEOUT_CYC=16, grant q7, no matching beat (a user=16'h0001 beat is injected) -> o_timeout_err pulses 16 cycles after GRANT and the FSM returns to IDLE.
REQ-035 Single-beat and ignored-request test: a matching beat with last=1 in WAIT_TX -> IDLE next cycle; i_queue_vld pulses during SEND -> no extra grant.
REQ-036 Reset test: i_rst asserted in SEND -> all outputs 0 immediately; after release, vld with 8'h10 -> grant 8'h10.
